rcv_phy_deframer: RTL and testbench
===================================

Name: rcv_phy_deframer

Overview:
- Receive-side counterpart of the transmit PHY path.
- Samples the 4-bit PHY nibble stream, strips the preamble and SFD, and reassembles bytes (low nibble first).
- Emits bytes with a data-valid strobe. At end of frame it emits a 24-bit control block (length, sequence, error flags) with a frame-valid strobe.
- Sits between the PHY pins and the receive frame buffer, entirely in the clk_phy domain.

Parameters:
- MAX_LEN, 1518: maximum delivered frame length in bytes (must be ≤ 4095).
- MIN_LEN, 64: minimum legal frame length in bytes; shorter frames are flagged runt.

Ports:
- clk_phy  input  1  PHY clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- phy_rx_dv  input  1  receive data valid from PHY; high for preamble+SFD+data.
- phy_data_in  input  4  receive nibble.
- r_data_out  output  8  reassembled byte.
- r_data_valid  output  1  one-cycle strobe; r_data_out is valid this cycle.
- r_ctrl_out  output  24  frame control block; valid only while r_frame_valid=1.
- r_frame_valid  output  1  one-cycle end-of-frame strobe.
- r_discard_en  output  1  one-cycle strobe, coincident with r_frame_valid, when any error bit is set.

Behaviour:
- Reset: synchronous, active-high (reset sampled high on a clk_phy rising edge).
  - All outputs go to 0.
  - State goes to IDLE; nibble phase, byte count, error flags and the 10-bit sequence counter are cleared.
  - Reset mid-frame: no r_frame_valid is produced for the aborted frame.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - phy_rx_dv=1 → PREAMBLE. The nibble sampled this cycle is evaluated as a preamble nibble, using the PREAMBLE rules below.
- PREAMBLE:
  - nibble 0x5 → stay.
  - nibble 0xD (SFD) → DATA, with phase=0, count=0 and flags cleared.
  - any other nibble → DROP.
  - phy_rx_dv=0 → IDLE; no outputs are produced.
- DATA:
  - phase 0: latch the nibble as the low half.
  - phase 1: form {nibble, low}. On the next cycle, r_data_out holds that byte and r_data_valid=1 (latency 1 clock after the high nibble is sampled).
  - count increments per byte, so r_data_valid strobes at most every other cycle.
  - When count == MAX_LEN, further bytes are not emitted, too_long is set, and count saturates.
- End of frame (phy_rx_dv=0 while in DATA):
  - Next cycle: r_frame_valid=1 and r_ctrl_out valid.
  - r_discard_en=1 in the same cycle if bit1 or bit0 is set.
  - The sequence counter increments after the strobe and wraps 1023→0. It increments for errored frames too.
  - State → IDLE.
  - If phy_rx_dv is high again on the cycle after the end, that nibble is taken as preamble. A one-cycle inter-frame gap is legal.
- DROP: wait for phy_rx_dv=0 → IDLE. No byte or frame outputs.
- Control block format:
  - [23:12] delivered byte count.
  - [11:2] frame sequence number.
  - [1] length error: count < MIN_LEN or too_long.
  - [0] alignment error: phase=1 at end of frame; the trailing half nibble is discarded.
- Outputs: r_data_out and r_ctrl_out hold their last value when their strobes are low. r_data_valid and r_frame_valid must never be asserted in the same cycle.

Test Plan:
- Good frame: 15 nibbles 0x5, then 0xD, then 64 bytes 0x00..0x3F low nibble first, then phy_rx_dv=0.
  → 64 r_data_valid pulses carrying 0x00..0x3F in order, 2 cycles apart.
  → r_frame_valid with r_ctrl_out=0x040000 and r_discard_en=0.
- Back-to-back: three 512-byte frames with a 1-cycle phy_rx_dv gap.
  → r_ctrl_out = 0x200000, 0x200004, 0x200008; no bytes lost.
- Alignment: 64 bytes plus one extra nibble 0xA.
  → 64 bytes delivered; r_ctrl_out=0x040001; r_discard_en=1.
- Runt and too-long:
  - 10-byte frame → r_ctrl_out=0x00A002, r_discard_en=1.
  - 1600-byte frame with MAX_LEN=1518 → exactly 1518 r_data_valid pulses; r_ctrl_out[23:12]=0x5EE; bit1=1.
- Bad preamble nibble 0x7 → DROP; no r_data_valid or r_frame_valid until the next good frame, which delivers normally.
- Reset asserted for 2 cycles after 100 data bytes of a frame, with phy_rx_dv still high.
  → all outputs 0 and no frame strobe for the aborted frame.
  → the following good 64-byte frame reports r_ctrl_out=0x040000 (sequence restarted at 0).

Source files
------------

// File: rtl/rcv_phy_deframer.sv
// Receive PHY deframer: strips preamble/SFD from the 4-bit PHY stream, rebuilds
// bytes low nibble first and reports a 24-bit control block at end of frame.
module rcv_phy_deframer #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic        phy_rx_dv,
  input  logic [3:0]  phy_data_in,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_valid,
  output logic        r_discard_en
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state, state_nx;
  logic        phase, phase_nx;
  logic [3:0]  low, low_nx;
  logic [11:0] count, count_nx;
  logic        too_long, too_long_nx;
  logic [9:0]  seq, seq_nx;
  logic [7:0]  data_nx;
  logic        data_valid_nx;
  logic [23:0] ctrl_nx;
  logic        frame_valid_nx;
  logic        discard_nx;
  logic        len_err;
  logic        align_err;

  // State and registered outputs; reset also aborts any frame in flight.
  always_ff @(posedge clk_phy) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= 1'b0;
      low           <= 4'h0;
      count         <= 12'd0;
      too_long      <= 1'b0;
      seq           <= 10'd0;
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_ctrl_out    <= 24'h000000;
      r_frame_valid <= 1'b0;
      r_discard_en  <= 1'b0;
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      low           <= low_nx;
      count         <= count_nx;
      too_long      <= too_long_nx;
      seq           <= seq_nx;
      r_data_out    <= data_nx;
      r_data_valid  <= data_valid_nx;
      r_ctrl_out    <= ctrl_nx;
      r_frame_valid <= frame_valid_nx;
      r_discard_en  <= discard_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx       = state;
    phase_nx       = phase;
    low_nx         = low;
    count_nx       = count;
    too_long_nx    = too_long;
    seq_nx         = seq;
    data_nx        = r_data_out;
    data_valid_nx  = 1'b0;
    ctrl_nx        = r_ctrl_out;
    frame_valid_nx = 1'b0;
    discard_nx     = 1'b0;
    len_err        = (count < 12'(MIN_LEN)) || too_long;
    align_err      = phase;

    case (state)
      // IDLE treats its first valid nibble exactly like a preamble nibble.
      IDLE, PREAMBLE: begin
        if (phy_rx_dv) begin
          if (phy_data_in == 4'h5) begin
            state_nx = PREAMBLE;
          end else if (phy_data_in == 4'hD) begin
            state_nx    = DATA;
            phase_nx    = 1'b0;
            count_nx    = 12'd0;
            too_long_nx = 1'b0;
          end else begin
            state_nx = DROP;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (!phy_rx_dv) begin
          frame_valid_nx = 1'b1;
          ctrl_nx        = {count, seq, len_err, align_err};
          discard_nx     = len_err | align_err;
          seq_nx         = seq + 10'd1;
          phase_nx       = 1'b0;
          state_nx       = IDLE;
        end else if (!phase) begin
          low_nx   = phy_data_in;
          phase_nx = 1'b1;
        end else begin
          phase_nx = 1'b0;
          // Bytes past MAX_LEN are dropped; the count stays saturated.
          if (count == 12'(MAX_LEN)) begin
            too_long_nx = 1'b1;
          end else begin
            count_nx      = count + 12'd1;
            data_nx       = {phy_data_in, low};
            data_valid_nx = 1'b1;
          end
        end
      end
      DROP: begin
        if (!phy_rx_dv) begin
          state_nx = IDLE;
        end else begin
          state_nx = DROP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rcv_phy_deframer.sv
// Bench for rcv_phy_deframer: directed and random frames scored against a
// queue-based model of delivered bytes and control blocks.
module tb_rcv_phy_deframer;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;

  logic        clk_phy = 1'b0;
  logic        reset = 1'b1;
  logic        phy_rx_dv = 1'b0;
  logic [3:0]  phy_data_in = 4'h0;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic [23:0] r_ctrl_out;
  logic        r_frame_valid;
  logic        r_discard_en;

  rcv_phy_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk_phy(clk_phy), .reset(reset), .phy_rx_dv(phy_rx_dv), .phy_data_in(phy_data_in),
    .r_data_out(r_data_out), .r_data_valid(r_data_valid), .r_ctrl_out(r_ctrl_out),
    .r_frame_valid(r_frame_valid), .r_discard_en(r_discard_en)
  );

  always #5 clk_phy = ~clk_phy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_bytes[$];
  logic [23:0] exp_ctrl[$];
  logic [7:0]  frame[$];
  logic [9:0]  m_seq = 10'd0;
  logic [7:0]  last_byte = 8'h00;
  logic [23:0] last_ctrl = 24'h000000;
  int n_pulses = 0;
  int cyc = 0;
  int last_dv_cyc = -10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output scoreboard, sampled on the falling edge.
  always @(negedge clk_phy) begin
    logic [7:0]  eb;
    logic [23:0] ec;
    cyc++;
    chk("strobe_exclusive", 32'(r_data_valid & r_frame_valid), 32'd0);
    if (r_data_valid) begin
      chk("byte_spacing", 32'(cyc - last_dv_cyc >= 2), 32'd1);
      last_dv_cyc = cyc;
      n_pulses++;
      if (exp_bytes.size() == 0) begin
        chk("unexpected_byte", 32'(r_data_out), 32'hFFFF_FFFF);
      end else begin
        eb = exp_bytes.pop_front();
        chk("byte", 32'(r_data_out), 32'(eb));
        last_byte = eb;
      end
    end else begin
      chk("data_hold", 32'(r_data_out), 32'(last_byte));
    end
    if (r_frame_valid) begin
      if (exp_ctrl.size() == 0) begin
        chk("unexpected_frame", 32'(r_ctrl_out), 32'hFFFF_FFFF);
      end else begin
        ec = exp_ctrl.pop_front();
        chk("ctrl", 32'(r_ctrl_out), 32'(ec));
        chk("discard", 32'(r_discard_en), 32'(ec[1] | ec[0]));
        last_ctrl = ec;
      end
    end else begin
      chk("ctrl_hold", 32'(r_ctrl_out), 32'(last_ctrl));
      chk("discard_idle", 32'(r_discard_en), 32'd0);
    end
  end

  task automatic drive(input logic dv, input logic [3:0] nib);
    phy_rx_dv   = dv;
    phy_data_in = nib;
    @(posedge clk_phy);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0);
  endtask

  // Sends frame[] and records what a correct deframer must deliver for it.
  task automatic send_frame(input int pre_len, input bit extra, input int gap);
    int n;
    int cnt;
    logic [11:0] c12;
    logic len_err;
    n = frame.size();
    for (int i = 0; i < pre_len; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < n; i++) begin
      if (i < MAX_LEN) exp_bytes.push_back(frame[i]);
      drive(1'b1, frame[i][3:0]);
      drive(1'b1, frame[i][7:4]);
    end
    if (extra) drive(1'b1, 4'hA);
    cnt = (n > MAX_LEN) ? MAX_LEN : n;
    c12 = 12'(cnt);
    len_err = (n < MIN_LEN) || (n > MAX_LEN);
    exp_ctrl.push_back({c12, m_seq, len_err, extra});
    m_seq = m_seq + 10'd1;
    idle(gap);
  endtask

  task automatic fill_inc(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
  endtask

  task automatic check_drained(input string tag);
    idle(4);
    chk({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    chk({tag, "_frames_left"}, 32'(exp_ctrl.size()), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    reset = 1'b1;
    drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);
    chk("rst_data", 32'(r_data_out), 32'd0);
    chk("rst_dv", 32'(r_data_valid), 32'd0);
    chk("rst_ctrl", 32'(r_ctrl_out), 32'd0);
    chk("rst_fv", 32'(r_frame_valid), 32'd0);
    chk("rst_disc", 32'(r_discard_en), 32'd0);
    reset = 1'b0;
    idle(2);

    // Good 64-byte frame.
    n_pulses = 0;
    fill_inc(64);
    send_frame(15, 1'b0, 1);
    check_drained("good");
    chk("good_ctrl", 32'(last_ctrl), 32'h040000);
    chk("good_pulses", 32'(n_pulses), 32'd64);

    // Three 512-byte frames with one-cycle gaps.
    n_pulses = 0;
    for (int f = 0; f < 3; f++) begin
      fill_rand(512);
      send_frame(7, 1'b0, 1);
    end
    check_drained("b2b");
    chk("b2b_pulses", 32'(n_pulses), 32'd1536);
    chk("b2b_len", 32'(last_ctrl[23:12]), 32'h200);

    // Trailing half nibble.
    fill_inc(64);
    send_frame(15, 1'b1, 2);
    check_drained("align");
    chk("align_len", 32'(last_ctrl[23:12]), 32'd64);
    chk("align_flags", 32'(last_ctrl[1:0]), 32'd1);

    // Runt.
    fill_rand(10);
    send_frame(3, 1'b0, 2);
    check_drained("runt");
    chk("runt_len", 32'(last_ctrl[23:12]), 32'd10);
    chk("runt_flags", 32'(last_ctrl[1:0]), 32'd2);

    // Too long.
    n_pulses = 0;
    fill_rand(1600);
    send_frame(15, 1'b0, 2);
    check_drained("long");
    chk("long_pulses", 32'(n_pulses), 32'd1518);
    chk("long_len", 32'(last_ctrl[23:12]), 32'h5EE);
    chk("long_bit1", 32'(last_ctrl[1]), 32'd1);

    // Bad preamble nibble, then a good frame.
    n_pulses = 0;
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h7);
    for (int i = 0; i < 20; i++) drive(1'b1, 4'($urandom));
    idle(2);
    chk("drop_pulses", 32'(n_pulses), 32'd0);
    fill_rand(64);
    send_frame(15, 1'b0, 1);
    check_drained("after_drop");
    chk("after_drop_pulses", 32'(n_pulses), 32'd64);

    // Random frames, including runts and odd nibble counts.
    for (int f = 0; f < 6; f++) begin
      fill_rand($urandom_range(1, 200));
      send_frame($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end
    check_drained("rand");

    // Reset after 100 data bytes with phy_rx_dv still high.
    fill_rand(100);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 100; i++) begin
      exp_bytes.push_back(frame[i]);
      drive(1'b1, frame[i][3:0]);
      drive(1'b1, frame[i][7:4]);
    end
    reset = 1'b1;
    drive(1'b1, 4'h0);
    last_byte = 8'h00;
    last_ctrl = 24'h000000;
    m_seq = 10'd0;
    chk("mid_rst_data", 32'(r_data_out), 32'd0);
    chk("mid_rst_dv", 32'(r_data_valid), 32'd0);
    chk("mid_rst_ctrl", 32'(r_ctrl_out), 32'd0);
    chk("mid_rst_fv", 32'(r_frame_valid), 32'd0);
    drive(1'b1, 4'h0);
    reset = 1'b0;
    drive(1'b1, 4'h3);
    idle(2);
    check_drained("abort");
    fill_inc(64);
    send_frame(15, 1'b0, 1);
    check_drained("post_rst");
    chk("post_rst_ctrl", 32'(last_ctrl), 32'h040000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
